// File: rtl/sm83_clk_pkg.sv
// Shared types and phase decode for the SM83 master clock/phase generator.
// Each CLKn is a bit mask over the eight phases; CLK2/5/7/9 are complements.
package sm83_clk_pkg;

  typedef logic [2:0] phase_t;

  localparam phase_t PH_FIRST = 3'd0;
  localparam phase_t PH_LAST  = 3'd7;

  localparam logic [7:0] CLK1_SET = 8'b0000_1111;
  localparam logic [7:0] CLK3_SET = 8'b1100_0000;
  localparam logic [7:0] CLK4_SET = 8'b0011_1100;
  localparam logic [7:0] CLK6_SET = 8'b0001_1110;
  localparam logic [7:0] CLK8_SET = 8'b0000_0001;

  typedef struct packed {
    logic clk1;
    logic clk2;
    logic clk3;
    logic clk4;
    logic clk5;
    logic clk6;
    logic clk7;
    logic clk8;
    logic clk9;
  } clk_phases_t;

  function automatic clk_phases_t clk_decode(input phase_t ph);
    clk_phases_t d;
    d.clk1 = CLK1_SET[ph];
    d.clk2 = ~CLK1_SET[ph];
    d.clk3 = CLK3_SET[ph];
    d.clk4 = CLK4_SET[ph];
    d.clk5 = ~CLK4_SET[ph];
    d.clk6 = CLK6_SET[ph];
    d.clk7 = ~CLK6_SET[ph];
    d.clk8 = CLK8_SET[ph];
    d.clk9 = ~CLK8_SET[ph];
    return d;
  endfunction

endpackage

// File: rtl/sm83_clkgen_if.sv
// Handshake and phase bundle between the clock generator (master) and the SM83 core (slave).
interface sm83_clkgen_if;
  logic       OSC_ENA;
  logic       CLK_ENA;
  logic       OSC_STABLE;
  logic       SYNC_RESET;
  logic       CLK1;
  logic       CLK2;
  logic       CLK3;
  logic       CLK4;
  logic       CLK5;
  logic       CLK6;
  logic       CLK7;
  logic       CLK8;
  logic       CLK9;
  logic [2:0] PHASE;

  modport master (
    input  OSC_ENA, CLK_ENA,
    output OSC_STABLE, SYNC_RESET, CLK1, CLK2, CLK3, CLK4, CLK5, CLK6, CLK7, CLK8, CLK9, PHASE
  );

  modport slave (
    output OSC_ENA, CLK_ENA,
    input  OSC_STABLE, SYNC_RESET, CLK1, CLK2, CLK3, CLK4, CLK5, CLK6, CLK7, CLK8, CLK9, PHASE
  );
endinterface

// File: rtl/sm83_osc_stab_timer.sv
// Oscillator stabilisation timer: OSC_STABLE rises after STABLE_CYCLES edges of OSC_ENA=1.
module sm83_osc_stab_timer #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic CLK,
  input  logic rst_i,
  input  logic OSC_ENA,
  output logic OSC_STABLE
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [CW-1:0] r_count;
  logic          r_stable;

  // Saturating count; dropping OSC_ENA restarts the whole wait.
  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i) begin
      r_count  <= '0;
      r_stable <= 1'b0;
    end else if (!OSC_ENA) begin
      r_count  <= '0;
      r_stable <= 1'b0;
    end else if (r_count != CNT_MAX) begin
      r_count <= r_count + 1'b1;
      if (r_count == CNT_MAX - 1'b1)
        r_stable <= 1'b1;
    end
  end

  assign OSC_STABLE = r_stable;

endmodule

// File: rtl/sm83_clkgen.sv
// SM83 master clock/phase generator: 8-phase M-cycle, reset synchroniser,
// halt/stop handling and M-cycle aligned SYNC_RESET.
module sm83_clkgen
  import sm83_clk_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int RESET_MCYCLES = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  sm83_clkgen_if.master bus
);

  localparam int RW = $clog2(RESET_MCYCLES + 2);
  localparam logic [RW-1:0] RCNT_MAX = RW'(RESET_MCYCLES + 1);

  logic [1:0]    r_rstSync;
  logic          w_rstInt;
  logic          w_oscStable;
  phase_t        r_ph;
  phase_t        w_phNext;
  logic          w_mcycStart;
  clk_phases_t   r_clk;
  logic [RW-1:0] r_rcnt;
  logic          r_syncReset;

  // Assert immediately with RESET, release two edges after it falls.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      r_rstSync <= 2'b11;
    else
      r_rstSync <= {r_rstSync[0], 1'b0};
  end

  assign w_rstInt = r_rstSync[1];

  sm83_osc_stab_timer #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stab (
    .CLK       (CLK),
    .rst_i     (w_rstInt),
    .OSC_ENA   (bus.OSC_ENA),
    .OSC_STABLE(w_oscStable)
  );

  // A started M-cycle always finishes; the run/hold choice is made only at the last phase.
  always_comb begin
    w_phNext = r_ph + 3'd1;
    if (r_ph == PH_LAST)
      w_phNext = (bus.CLK_ENA && w_oscStable) ? PH_FIRST : PH_LAST;
  end

  assign w_mcycStart = (r_ph == PH_LAST) && (w_phNext == PH_FIRST);

  always_ff @(posedge CLK or posedge w_rstInt) begin
    if (w_rstInt) begin
      r_ph  <= PH_LAST;
      r_clk <= clk_decode(PH_LAST);
    end else begin
      r_ph  <= w_phNext;
      r_clk <= clk_decode(w_phNext);
    end
  end

  // SYNC_RESET covers RESET_MCYCLES whole M-cycles, then stays low until the next reset.
  always_ff @(posedge CLK or posedge w_rstInt) begin
    if (w_rstInt) begin
      r_rcnt      <= '0;
      r_syncReset <= 1'b1;
    end else if (w_mcycStart && (r_rcnt != RCNT_MAX)) begin
      r_rcnt <= r_rcnt + 1'b1;
      if (r_rcnt == RCNT_MAX - 1'b1)
        r_syncReset <= 1'b0;
    end
  end

  assign bus.OSC_STABLE = w_oscStable;
  assign bus.SYNC_RESET = r_syncReset;
  assign bus.CLK1       = r_clk.clk1;
  assign bus.CLK2       = r_clk.clk2;
  assign bus.CLK3       = r_clk.clk3;
  assign bus.CLK4       = r_clk.clk4;
  assign bus.CLK5       = r_clk.clk5;
  assign bus.CLK6       = r_clk.clk6;
  assign bus.CLK7       = r_clk.clk7;
  assign bus.CLK8       = r_clk.clk8;
  assign bus.CLK9       = r_clk.clk9;
  assign bus.PHASE      = r_ph;

endmodule

// File: tb/tb_sm83_clkgen.sv
// Directed bench for sm83_clkgen: reset/stabilisation timing, free-run decode,
// SYNC_RESET length, CLK_ENA halt, OSC_ENA stop and mid-cycle RESET.
module tb_sm83_clkgen;

  // Expected {CLK1..CLK9} per phase, worked out by hand from the phase sets.
  localparam logic [8:0] EXP_DEC [8] = '{
    9'b100010110,
    9'b100011001,
    9'b100101001,
    9'b100101001,
    9'b010101001,
    9'b010100101,
    9'b011010101,
    9'b011010101
  };

  logic CLK;
  logic RESET;
  int   nCompared;
  int   nMismatched;

  sm83_clkgen_if bus();

  sm83_clkgen #(
    .STABLE_CYCLES(16),
    .RESET_MCYCLES(2)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic reset, input logic oscEna, input logic clkEna);
    RESET       = reset;
    bus.OSC_ENA = oscEna;
    bus.CLK_ENA = clkEna;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkPhase(input string tag, input int ph);
    logic [8:0] clks;
    clks = {bus.CLK1, bus.CLK2, bus.CLK3, bus.CLK4, bus.CLK5, bus.CLK6, bus.CLK7, bus.CLK8, bus.CLK9};
    checkOutput({tag, "_phase"}, {6'd0, bus.PHASE}, 9'(ph));
    checkOutput({tag, "_clks"}, clks, EXP_DEC[ph]);
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;

    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(3);
    $display("[TB] reset state");
    checkPhase("reset", 7);
    checkOutput("reset_clks_literal",
                {bus.CLK1, bus.CLK2, bus.CLK3, bus.CLK4, bus.CLK5, bus.CLK6, bus.CLK7, bus.CLK8, bus.CLK9},
                9'b011010101);
    checkOutput("reset_osc_stable", {8'd0, bus.OSC_STABLE}, 9'd0);
    checkOutput("reset_sync_reset", {8'd0, bus.SYNC_RESET}, 9'd1);

    $display("[TB] reset release and stabilisation");
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick(17);
    checkOutput("stab17_osc_stable", {8'd0, bus.OSC_STABLE}, 9'd0);
    checkPhase("stab17", 7);
    tick(1);
    checkOutput("stab18_osc_stable", {8'd0, bus.OSC_STABLE}, 9'd1);
    checkPhase("stab18", 7);
    tick(1);
    checkPhase("first_m0", 0);
    checkOutput("first_m0_sync_reset", {8'd0, bus.SYNC_RESET}, 9'd1);

    $display("[TB] free run over three M-cycles");
    for (int i = 1; i <= 24; i++) begin
      tick(1);
      checkPhase($sformatf("run%0d", i), i % 8);
      checkOutput($sformatf("run%0d_sync_reset", i), {8'd0, bus.SYNC_RESET}, (i < 16) ? 9'd1 : 9'd0);
    end

    $display("[TB] CLK_ENA halt at phase 3");
    tick(3);
    checkPhase("halt_pre", 3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 4; i <= 7; i++) begin
      tick(1);
      checkPhase($sformatf("halt_run%0d", i), i);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkPhase($sformatf("halt_hold%0d", i), 7);
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick(1);
    checkPhase("halt_resume", 0);
    checkOutput("halt_resume_clk8", {8'd0, bus.CLK8}, 9'd1);
    checkOutput("halt_resume_sync_reset", {8'd0, bus.SYNC_RESET}, 9'd0);

    $display("[TB] OSC_ENA stop at phase 4");
    tick(4);
    checkPhase("stop_pre", 4);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("stop_osc_stable", {8'd0, bus.OSC_STABLE}, 9'd0);
    checkPhase("stop_run5", 5);
    tick(2);
    checkPhase("stop_run7", 7);
    tick(2);
    checkPhase("stop_hold", 7);
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick(15);
    checkOutput("restab15_osc_stable", {8'd0, bus.OSC_STABLE}, 9'd0);
    checkPhase("restab15", 7);
    tick(1);
    checkOutput("restab16_osc_stable", {8'd0, bus.OSC_STABLE}, 9'd1);
    checkPhase("restab16", 7);
    tick(1);
    checkPhase("restab_resume", 0);

    $display("[TB] RESET pulse at phase 5");
    tick(5);
    checkPhase("rst_pre", 5);
    applyStimulus(1'b1, 1'b1, 1'b1);
    #1;
    checkPhase("rst_async", 7);
    checkOutput("rst_async_clk2_clk3", {7'd0, bus.CLK2, bus.CLK3}, 9'b11);
    checkOutput("rst_async_sync_reset", {8'd0, bus.SYNC_RESET}, 9'd1);
    checkOutput("rst_async_osc_stable", {8'd0, bus.OSC_STABLE}, 9'd0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick(17);
    checkOutput("rst2_17_osc_stable", {8'd0, bus.OSC_STABLE}, 9'd0);
    tick(1);
    checkOutput("rst2_18_osc_stable", {8'd0, bus.OSC_STABLE}, 9'd1);
    checkPhase("rst2_18", 7);
    tick(1);
    checkPhase("rst2_m0", 0);
    checkOutput("rst2_m0_sync_reset", {8'd0, bus.SYNC_RESET}, 9'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
